l1_arbiter: RTL and testbench

Two-to-one line-request arbiter inside `cache_hierarchy`, directly downstream of the L1 instruction and data caches. Accepts independent line-fill and writeback requests from both L1 caches and serialises them onto the single lower-level memory port (physical memory now, L2 later). Grants alternate between the two requesters when both are waiting. Returns the line and a one-cycle response to whichever cache owns the transaction.

---
 rtl/lc3b_types.sv | 16 +
 rtl/l1_arbiter.sv | 123 ++++++++++++
 tb/tb_l1_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b cache-hierarchy types.
//   lc3b_word      : 16-bit address / data word
//   lc3b_L1_line   : 128-bit L1 cache line
//   lc3b_arb_state : state of the L1-to-lower-level arbiter
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_L1_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/l1_arbiter.sv
// Two-to-one line-request arbiter between the L1 icache/dcache and the single
// lower-level memory port. Grants alternate when both caches wait; the owner
// of the current transaction gets the line and a one-cycle resp.
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   i_read, i_address           icache fill request (held until i_resp)
//   i_rdata, i_resp             icache line and completion pulse
//   d_read, d_write, d_address  dcache fill / writeback request (held until d_resp)
//   d_wdata                     dcache writeback line
//   d_rdata, d_resp             dcache line and completion pulse
//   pmem_read, pmem_write       lower-level request, held until pmem_resp
//   pmem_address, pmem_wdata    line-aligned lower-level address and write line
//   pmem_rdata, pmem_resp       lower-level read line and completion
//
// state   | meaning
// IDLE    | no transaction; arbitrate on the next edge
// SERVE_I | icache transaction outstanding on the lower level
// SERVE_D | dcache transaction outstanding on the lower level
module l1_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned LINE_OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_read,
  input  lc3b_word    i_address,
  output lc3b_L1_line i_rdata,
  output logic        i_resp,

  input  logic        d_read,
  input  logic        d_write,
  input  lc3b_word    d_address,
  input  lc3b_L1_line d_wdata,
  output lc3b_L1_line d_rdata,
  output logic        d_resp,

  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_word    pmem_address,
  output lc3b_L1_line pmem_wdata,
  input  lc3b_L1_line pmem_rdata,
  input  logic        pmem_resp
);

  localparam lc3b_word LINE_MASK = ~lc3b_word'((32'd1 << LINE_OFFSET_BITS) - 32'd1);

  lc3b_arb_state state_q;
  logic          last_grant_q;   // 0 = icache served last, 1 = dcache
  lc3b_word      addr_q;
  lc3b_L1_line   wdata_q;
  logic          pmem_read_q;
  logic          pmem_write_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  // Dcache wins when it is alone, or on a tie when the icache went last.
  assign grant_d = d_req & (~i_req | ~last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            last_grant_q <= grant_d;
            if (grant_d) begin
              state_q      <= SERVE_D;
              addr_q       <= d_address & LINE_MASK;
              wdata_q      <= d_wdata;
              // Read and write together is illegal; the writeback wins.
              pmem_write_q <= d_write;
              pmem_read_q  <= ~d_write;
            end else begin
              state_q      <= SERVE_I;
              addr_q       <= i_address & LINE_MASK;
              pmem_write_q <= 1'b0;
              pmem_read_q  <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          // The transaction finishes even if the requester has already
          // dropped its request.
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Same-cycle completion; rdata is passed through and qualified by resp.
  assign i_resp  = pmem_resp & (state_q == SERVE_I);
  assign d_resp  = pmem_resp & (state_q == SERVE_D);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_l1_arbiter.sv
module tb_l1_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: which caches are waiting, and who was served last
  // (1 = dcache), reset so that the icache wins the first tie.
  bit i_pend;
  bit d_pend;
  bit model_last;

  always #5 clk = ~clk;

  l1_arbiter #(.LINE_OFFSET_BITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic raise_i(input logic [15:0] addr);
    i_read    = 1'b1;
    i_address = addr;
    i_pend    = 1'b1;
  endtask

  task automatic raise_d(input logic [15:0] addr, input bit rd, input bit wr,
                         input logic [127:0] wd);
    d_read    = rd;
    d_write   = wr;
    d_address = addr;
    d_wdata   = wd;
    d_pend    = 1'b1;
  endtask

  // Ends just after a rising edge with the arbiter idle.
  task automatic do_reset();
    rst_n      = 1'b0;
    i_read     = 1'b0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    i_pend     = 1'b0;
    d_pend     = 1'b0;
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge while the arbiter is idle and at least
  // one request is pending. Plays the lower level with the given latency.
  task automatic run_txn(input int lat, input logic [127:0] rdata);
    bit          own_d;
    bit          ew;
    logic [15:0] ea;
    logic [127:0] ewd;
    if (i_pend && d_pend) own_d = !model_last;
    else                  own_d = d_pend;
    ew  = own_d && d_write;
    ea  = (own_d ? d_address : i_address) & 16'hFFF0;
    ewd = d_wdata;

    @(negedge clk);
    chk("idle_pmem_read", pmem_read, 0);
    chk("idle_pmem_write", pmem_write, 0);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("req_read", pmem_read, !ew);
      chk("req_write", pmem_write, ew);
      chk("req_addr", pmem_address, ea);
      if (ew) chk("req_wdata", pmem_wdata, ewd);
      if (c == lat) begin
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        chk("i_resp", i_resp, !own_d);
        chk("d_resp", d_resp, own_d);
        if (own_d) chk("d_rdata", d_rdata, rdata);
        else       chk("i_rdata", i_rdata, rdata);
      end else begin
        chk("early_i_resp", i_resp, 0);
        chk("early_d_resp", d_resp, 0);
      end
      @(posedge clk);
    end
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = rand128();
    if (own_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      d_pend  = 1'b0;
    end else begin
      i_read  = 1'b0;
      i_pend  = 1'b0;
    end
    model_last = own_d;
  endtask

  initial begin
    i_address = '0;
    d_address = '0;
    d_wdata   = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    @(posedge clk);
    #1;

    // Icache fill alone
    raise_i(16'h1236);
    run_txn(3, {16{8'hA5}});

    // Dcache writeback alone
    raise_d(16'h40F0, 1'b0, 1'b1, {2{64'h0123_4567_89AB_CDEF}});
    run_txn(2, rand128());

    // Simultaneous after reset: icache first, then strict alternation
    do_reset();
    raise_i(16'h1000);
    raise_d(16'h2000, 1'b1, 1'b0, rand128());
    for (int k = 0; k < 6; k++) begin
      run_txn(1 + k % 3, rand128());
      chk("alt_owner", {i_pend, d_pend}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (!i_pend) raise_i(16'h1000 + 16'(k * 16'h33));
      else         raise_d(16'h2000 + 16'(k * 16'h47), 1'b1, 1'b0, rand128());
    end
    run_txn(2, rand128());
    run_txn(2, rand128());

    // Read and write together -> writeback
    raise_d(16'h5A5F, 1'b1, 1'b1, rand128());
    run_txn(2, rand128());

    // Stray pmem_resp while idle
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("stray_i_resp", i_resp, 0);
    chk("stray_d_resp", d_resp, 0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("stray_pmem_read", pmem_read, 0);
    chk("stray_pmem_write", pmem_write, 0);
    @(posedge clk);
    #1;
    raise_i(16'h0ABC);
    raise_d(16'h0DEF, 1'b1, 1'b0, rand128());
    run_txn(1, rand128());
    run_txn(1, rand128());

    // Reset two cycles into an icache fill
    raise_i(16'h2468);
    @(posedge clk);
    @(negedge clk);
    chk("mid_pmem_read_1", pmem_read, 1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_pmem_read_2", pmem_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pmem_read", pmem_read, 0);
    chk("rst_async_i_resp", i_resp, 0);
    i_read = 1'b0;
    i_pend = 1'b0;
    d_pend = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held_pmem_read", pmem_read, 0);
    chk("rst_held_i_resp", i_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    @(posedge clk);
    #1;
    raise_i(16'h0100);
    raise_d(16'h0200, 1'b0, 1'b1, rand128());
    run_txn(2, rand128());
    chk("post_rst_first", {i_pend, d_pend}, 2'b01);
    run_txn(2, rand128());

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!i_pend && ($urandom_range(0, 1) == 1)) raise_i(16'($urandom()));
      if (!d_pend && ($urandom_range(0, 1) == 1)) begin
        case ($urandom_range(0, 4))
          0, 1:    raise_d(16'($urandom()), 1'b1, 1'b0, rand128());
          2, 3:    raise_d(16'($urandom()), 1'b0, 1'b1, rand128());
          default: raise_d(16'($urandom()), 1'b1, 1'b1, rand128());
        endcase
      end
      if (!i_pend && !d_pend) raise_i(16'($urandom()));
      run_txn($urandom_range(1, 4), rand128());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
